// File: rtl/load_store_unit_if.sv
// Bundle of execute-stage, memory-port and writeback/fault signals around the load/store unit.
// The unit itself uses the slave view; whatever surrounds it uses the master view.
interface load_store_unit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_done;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [2:0]  fault_cause;
    logic [31:0] fault_addr;

    modport slave (
        input  ex_valid, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        input  mem_dout, mem_done,
        output ex_ready,
        output mem_req, mem_addr, mem_we, mem_din,
        output wb_valid, wb_rd, wb_data, fault, fault_cause, fault_addr
    );

    modport master (
        output ex_valid, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        output mem_dout, mem_done,
        input  ex_ready,
        input  mem_req, mem_addr, mem_we, mem_din,
        input  wb_valid, wb_rd, wb_data, fault, fault_cause, fault_addr
    );
endinterface

// File: rtl/load_store_unit.sv
// Port-B load/store front end: one RISC-V load or store per transaction, with
// lane shifting, load extension, fault classification and a request timeout.
//
// state | meaning
// IDLE  | ex_ready high, waiting for an op
// REQ   | mem_req held with stable address/enables/data until mem_done or timeout
// RESP  | one-cycle wb_valid pulse with extended load data or store acknowledge
// FAULT | one-cycle fault pulse, no memory request was issued
module load_store_unit #(
    parameter logic [31:0] ROM_UPPER_ADDR = 32'h7fff_ffff,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input logic         clk,
    input logic         rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] addrQ;
    logic [2:0]  funct3Q;
    logic        isStoreQ;
    logic [4:0]  rdQ;
    logic [7:0]  reqCount;

    logic        illegalOp;
    logic        misaligned;
    logic [2:0]  acceptCause;
    logic [3:0]  storeMask;
    logic [31:0] storeData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    // Classification and lane shaping of the op being offered; only ever registered.
    always_comb begin
        if (bus.ex_is_store)
            illegalOp = (bus.ex_funct3 == 3'b011) || bus.ex_funct3[2];
        else
            illegalOp = (bus.ex_funct3 == 3'b011) || (bus.ex_funct3 == 3'b110) ||
                        (bus.ex_funct3 == 3'b111);

        case (bus.ex_funct3[1:0])
            2'b01:   misaligned = bus.ex_addr[0];
            2'b10:   misaligned = (bus.ex_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        acceptCause = 3'b000;
        if (illegalOp)
            acceptCause = 3'b100;
        else if (misaligned)
            acceptCause = bus.ex_is_store ? 3'b010 : 3'b001;
        else if (bus.ex_is_store && (bus.ex_addr <= ROM_UPPER_ADDR))
            acceptCause = 3'b011;

        case (bus.ex_funct3[1:0])
            2'b00: begin
                storeMask = 4'b0001 << bus.ex_addr[1:0];
                storeData = {4{bus.ex_wdata[7:0]}};
            end
            2'b01: begin
                storeMask = 4'b0011 << bus.ex_addr[1:0];
                storeData = {2{bus.ex_wdata[15:0]}};
            end
            default: begin
                storeMask = 4'b1111;
                storeData = bus.ex_wdata;
            end
        endcase
    end

    always_comb begin
        case (addrQ[1:0])
            2'b00:   loadByte = bus.mem_dout[7:0];
            2'b01:   loadByte = bus.mem_dout[15:8];
            2'b10:   loadByte = bus.mem_dout[23:16];
            default: loadByte = bus.mem_dout[31:24];
        endcase
        loadHalf = addrQ[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];

        case (funct3Q)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadData = {24'h000000, loadByte};
            3'b101:  loadData = {16'h0000, loadHalf};
            default: loadData = bus.mem_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            addrQ           <= '0;
            funct3Q         <= '0;
            isStoreQ        <= 1'b0;
            rdQ             <= '0;
            reqCount        <= '0;
            bus.ex_ready    <= 1'b1;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_we      <= '0;
            bus.mem_din     <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_rd       <= '0;
            bus.wb_data     <= '0;
            bus.fault       <= 1'b0;
            bus.fault_cause <= '0;
            bus.fault_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ex_valid) begin
                        addrQ        <= bus.ex_addr;
                        funct3Q      <= bus.ex_funct3;
                        isStoreQ     <= bus.ex_is_store;
                        rdQ          <= bus.ex_rd;
                        reqCount     <= '0;
                        bus.ex_ready <= 1'b0;
                        if (acceptCause != 3'b000) begin
                            state           <= FAULT;
                            bus.fault       <= 1'b1;
                            bus.fault_cause <= acceptCause;
                            bus.fault_addr  <= bus.ex_addr;
                        end else begin
                            state        <= REQ;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {bus.ex_addr[31:2], 2'b00};
                            bus.mem_we   <= bus.ex_is_store ? storeMask : 4'b0000;
                            bus.mem_din  <= bus.ex_is_store ? storeData : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_done) begin
                        state        <= RESP;
                        bus.mem_req  <= 1'b0;
                        bus.mem_we   <= 4'b0000;
                        bus.wb_valid <= 1'b1;
                        bus.wb_rd    <= isStoreQ ? 5'd0 : rdQ;
                        bus.wb_data  <= isStoreQ ? 32'h0 : loadData;
                    end else if (reqCount == LAST_COUNT) begin
                        state           <= FAULT;
                        bus.mem_req     <= 1'b0;
                        bus.mem_we      <= 4'b0000;
                        bus.fault       <= 1'b1;
                        bus.fault_cause <= 3'b101;
                        bus.fault_addr  <= addrQ;
                    end else begin
                        reqCount <= reqCount + 8'd1;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    bus.wb_valid <= 1'b0;
                    bus.ex_ready <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus.fault    <= 1'b0;
                    bus.ex_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout, mid-request reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    load_store_unit_if bus();

    load_store_unit #(
        .ROM_UPPER_ADDR(32'h7fff_ffff),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Offers one op for exactly one rising edge; returns in the cycle after acceptance.
    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        bus.ex_is_store = st;
        bus.ex_funct3   = f3;
        bus.ex_addr     = addr;
        bus.ex_wdata    = wdata;
        bus.ex_rd       = rd;
        bus.ex_valid    = 1'b1;
        @(negedge clk);
        bus.ex_valid    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ex_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_we !== 4'h0) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b req=%b we=%b exp ready=1 req=0 we=0000",
                     bus.ex_ready, bus.mem_req, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_din !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem got addr=%h din=%h exp 0", bus.mem_addr, bus.mem_din);
        end
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_wb got valid=%b rd=%0d data=%h exp 0", bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        checks++;
        if (bus.fault !== 1'b0 || bus.fault_cause !== 3'd0 || bus.fault_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_fault got fault=%b cause=%b addr=%h exp 0",
                     bus.fault, bus.fault_cause, bus.fault_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_word;
        present(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd5);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8000_0010 || bus.mem_we !== 4'b0000) begin
            failures++;
            $display("FAIL lw_req got req=%b addr=%h we=%b exp 1 80000010 0000",
                     bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.ex_ready !== 1'b0) begin
            failures++;
            $display("FAIL lw_busy got wb_valid=%b ready=%b exp 0 0", bus.wb_valid, bus.ex_ready);
        end
        bus.mem_done = 1'b1;
        bus.mem_dout = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_done = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hDEAD_BEEF || bus.wb_rd !== 5'd5) begin
            failures++;
            $display("FAIL lw_wb got valid=%b data=%h rd=%0d exp 1 deadbeef 5",
                     bus.wb_valid, bus.wb_data, bus.wb_rd);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL lw_req_drop got %b exp 0", bus.mem_req);
        end
        @(negedge clk);
        checks++;
        if (bus.ex_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL lw_ready got ready=%b wb_valid=%b exp 1 0", bus.ex_ready, bus.wb_valid);
        end
    endtask

    task automatic test_load_extend;
        logic [2:0]  f3[6]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b101};
        logic [31:0] addr[6] = '{32'h8000_0013, 32'h8000_0013, 32'h8000_0002,
                                 32'h8000_0002, 32'h8000_0011, 32'h8000_0000};
        logic [31:0] word[6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                                 32'h80FF_0000, 32'h1234_F678, 32'h1234_F678};
        logic [31:0] exp[6]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                 32'h0000_80FF, 32'hFFFF_FFF6, 32'h0000_F678};
        for (int i = 0; i < 6; i++) begin
            present(1'b0, f3[i], addr[i], 32'h0, 5'(i + 10));
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== {addr[i][31:2], 2'b00}) begin
                failures++;
                $display("FAIL ext_req[%0d] got req=%b addr=%h exp 1 %h",
                         i, bus.mem_req, bus.mem_addr, {addr[i][31:2], 2'b00});
            end
            bus.mem_done = 1'b1;
            bus.mem_dout = word[i];
            @(negedge clk);
            bus.mem_done = 1'b0;
            checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp[i] || bus.wb_rd !== 5'(i + 10)) begin
                failures++;
                $display("FAIL ext_wb[%0d] got valid=%b data=%h rd=%0d exp 1 %h %0d",
                         i, bus.wb_valid, bus.wb_data, bus.wb_rd, exp[i], i + 10);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3[3]    = '{3'b001, 3'b000, 3'b010};
        logic [31:0] addr[3]  = '{32'h8000_0006, 32'h8000_0001, 32'h8000_0008};
        logic [31:0] wdata[3] = '{32'h1234_ABCD, 32'h7766_555A, 32'hCAFE_F00D};
        logic [3:0]  we[3]    = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] din[3]   = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
        for (int i = 0; i < 3; i++) begin
            present(1'b1, f3[i], addr[i], wdata[i], 5'd17);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== we[i] || bus.mem_din !== din[i] ||
                bus.mem_addr !== {addr[i][31:2], 2'b00}) begin
                failures++;
                $display("FAIL st_req[%0d] got req=%b we=%b din=%h addr=%h exp 1 %b %h %h",
                         i, bus.mem_req, bus.mem_we, bus.mem_din, bus.mem_addr,
                         we[i], din[i], {addr[i][31:2], 2'b00});
            end
            // Hold a second REQ cycle to confirm the request stays stable.
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== we[i] || bus.mem_din !== din[i]) begin
                failures++;
                $display("FAIL st_hold[%0d] got req=%b we=%b din=%h exp 1 %b %h",
                         i, bus.mem_req, bus.mem_we, bus.mem_din, we[i], din[i]);
            end
            bus.mem_done = 1'b1;
            bus.mem_dout = 32'hFFFF_FFFF;
            @(negedge clk);
            bus.mem_done = 1'b0;
            checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
                failures++;
                $display("FAIL st_wb[%0d] got valid=%b rd=%0d data=%h exp 1 0 0",
                         i, bus.wb_valid, bus.wb_rd, bus.wb_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_faults;
        logic        st[6]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0]  f3[6]    = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100, 3'b010};
        logic [31:0] addr[6]  = '{32'h0000_0100, 32'h8000_0001, 32'h8000_0000,
                                  32'h8000_0002, 32'h0000_0003, 32'h7FFF_FFFC};
        logic [2:0]  cause[6] = '{3'b011, 3'b001, 3'b100, 3'b010, 3'b100, 3'b011};
        for (int i = 0; i < 6; i++) begin
            present(st[i], f3[i], addr[i], 32'h1111_2222, 5'd3);
            checks++;
            if (bus.fault !== 1'b1 || bus.fault_cause !== cause[i] || bus.fault_addr !== addr[i] ||
                bus.mem_req !== 1'b0 || bus.wb_valid !== 1'b0) begin
                failures++;
                $display("FAIL fault[%0d] got fault=%b cause=%b addr=%h req=%b wbv=%b exp 1 %b %h 0 0",
                         i, bus.fault, bus.fault_cause, bus.fault_addr, bus.mem_req, bus.wb_valid,
                         cause[i], addr[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.fault !== 1'b0 || bus.ex_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
                failures++;
                $display("FAIL fault_end[%0d] got fault=%b ready=%b req=%b exp 0 1 0",
                         i, bus.fault, bus.ex_ready, bus.mem_req);
            end
        end
    endtask

    task automatic test_timeout;
        int highCycles = 0;
        present(1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd4);
        for (int i = 0; i < 20 && bus.mem_req === 1'b1; i++) begin
            highCycles++;
            @(negedge clk);
        end
        checks++;
        if (highCycles != 4) begin
            failures++;
            $display("FAIL timeout_len got %0d req cycles exp 4", highCycles);
        end
        checks++;
        if (bus.fault !== 1'b1 || bus.fault_cause !== 3'b101 || bus.fault_addr !== 32'h8000_0020) begin
            failures++;
            $display("FAIL timeout_fault got fault=%b cause=%b addr=%h exp 1 101 80000020",
                     bus.fault, bus.fault_cause, bus.fault_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.ex_ready !== 1'b1 || bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL timeout_ready got ready=%b fault=%b exp 1 0", bus.ex_ready, bus.fault);
        end
    endtask

    task automatic test_reset_mid_request;
        present(1'b0, 3'b010, 32'h8000_0030, 32'h0, 5'd7);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_req got %b exp 1", bus.mem_req);
        end
        rst = 1'b1;
        bus.mem_done = 1'b1;
        bus.mem_dout = 32'h5555_AAAA;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.wb_valid !== 1'b0 || bus.fault !== 1'b0 ||
            bus.ex_ready !== 1'b1 || bus.mem_addr !== 32'h0 || bus.wb_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_state got req=%b wbv=%b fault=%b ready=%b addr=%h data=%h exp 0 0 0 1 0 0",
                     bus.mem_req, bus.wb_valid, bus.fault, bus.ex_ready, bus.mem_addr, bus.wb_data);
        end
        @(negedge clk);
        bus.mem_done = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_idle got wbv=%b req=%b ready=%b exp 0 0 1",
                     bus.wb_valid, bus.mem_req, bus.ex_ready);
        end
    endtask

    task automatic test_back_to_back;
        present(1'b0, 3'b010, 32'h8000_0040, 32'h0, 5'd9);
        // Next op offered while busy; it must wait until IDLE.
        bus.ex_is_store = 1'b1;
        bus.ex_funct3   = 3'b010;
        bus.ex_addr     = 32'h8000_0044;
        bus.ex_wdata    = 32'h0BAD_F00D;
        bus.ex_rd       = 5'd12;
        bus.ex_valid    = 1'b1;
        bus.mem_done    = 1'b1;
        bus.mem_dout    = 32'h2468_ACE0;
        @(negedge clk);
        bus.mem_done = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h2468_ACE0 || bus.wb_rd !== 5'd9 ||
            bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first got wbv=%b data=%h rd=%0d req=%b exp 1 2468ace0 9 0",
                     bus.wb_valid, bus.wb_data, bus.wb_rd, bus.mem_req);
        end
        @(negedge clk);
        checks++;
        if (bus.ex_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got ready=%b req=%b exp 1 0", bus.ex_ready, bus.mem_req);
        end
        @(negedge clk);
        bus.ex_valid = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 4'b1111 || bus.mem_din !== 32'h0BAD_F00D ||
            bus.mem_addr !== 32'h8000_0044) begin
            failures++;
            $display("FAIL b2b_second got req=%b we=%b din=%h addr=%h exp 1 1111 0badf00d 80000044",
                     bus.mem_req, bus.mem_we, bus.mem_din, bus.mem_addr);
        end
        bus.mem_done = 1'b1;
        @(negedge clk);
        bus.mem_done = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
            failures++;
            $display("FAIL b2b_second_wb got wbv=%b rd=%0d data=%h exp 1 0 0",
                     bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.ex_valid    = 1'b0;
        bus.ex_is_store = 1'b0;
        bus.ex_funct3   = 3'b000;
        bus.ex_addr     = 32'h0;
        bus.ex_wdata    = 32'h0;
        bus.ex_rd       = 5'd0;
        bus.mem_dout    = 32'h0;
        bus.mem_done    = 1'b0;
        @(negedge clk);
        test_reset;
        test_load_word;
        test_load_extend;
        test_stores;
        test_faults;
        test_timeout;
        test_reset_mid_request;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side front end for the data port (port B) of the memory-mapped IO block. It accepts one RISC-V load or store per transaction from the execute stage and drives a word-aligned request with byte enables and lane-shifted store data. It holds the request until the memory signals completion, then returns sign- or zero-extended load data (or a store acknowledge) to writeback. It also detects misaligned, illegal, ROM-store and timed-out accesses and reports them as faults without issuing a memory request.

## Interface
Parameters:
- ROM_UPPER_ADDR, 32'h7fff_ffff: addresses at or below this are ROM; stores there fault.
- TIMEOUT_CYCLES, 255: maximum REQ cycles before a timeout fault (8-bit counter; legal values 1..255).

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  operation presented
- ex_ready  out  1  unit can accept (high only in IDLE)
- ex_is_store  in  1  1 = store, 0 = load
- ex_funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data, right-justified
- ex_rd  in  5  load destination register
- mem_req  out  1  request to memory port
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_we  out  4  byte write enables; 0000 for loads
- mem_din  out  32  lane-shifted store data
- mem_dout  in  32  read word
- mem_done  in  1  memory completion for the current request
- wb_valid  out  1  one-cycle completion pulse
- wb_rd  out  5  ex_rd for loads, 0 for stores
- wb_data  out  32  extended load data, 0 for stores
- fault  out  1  one-cycle fault pulse
- fault_cause  out  3  001 load misaligned, 010 store misaligned, 011 store to ROM, 100 illegal funct3, 101 timeout
- fault_addr  out  32  ex_addr of the faulting op

## Operation
- States: IDLE, REQ, RESP, FAULT.
- IDLE: ex_ready=1. On an edge with ex_valid=1:
  - Latch addr, funct3, is_store, wdata and rd.
  - Classify the op. Any fault goes to FAULT; otherwise go to REQ.
- Fault classification, in priority order:
  1. illegal funct3 (load 011/110/111; store 011 or any 1xx)
  2. misaligned (half-word: addr[0]=1; word: addr[1:0]!=0)
  3. store with addr <= ROM_UPPER_ADDR
- REQ:
  - Outputs: mem_req=1; mem_addr, mem_we and mem_din stable for the whole state.
  - mem_we: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111.
  - mem_din: SB replicates byte ×4; SH replicates half ×2; SW passes the word.
  - Timeout counter starts at 0 on entry and increments each REQ cycle.
  - Edge with mem_done=1: capture mem_dout, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: go to FAULT with cause 101.
- RESP:
  - wb_valid=1 for this cycle only.
  - Load data is selected by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extended per funct3.
  - Next state is IDLE.
- FAULT: fault=1 for one cycle with cause and address; wb_valid=0; next state is IDLE.
- mem_done is ignored outside REQ.

## Timing
- Outputs are registered or derived from state and latched fields only; there is no combinational path from ex_* to mem_*.
- Reset values: state IDLE, ex_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, wb_valid=0, wb_rd=0, wb_data=0, fault=0, fault_cause=0, fault_addr=0.
- Latency: accept at edge N; mem_req high in cycle N+1; with mem_done in cycle N+1+k, wb_valid is high in cycle N+2+k; ex_ready returns in cycle N+3+k.
- Minimum issue interval is 3 cycles.
- Faults: accept at edge N gives fault in cycle N+1 and ex_ready in cycle N+2; mem_req stays 0 throughout.
- Timeout: mem_req is high for exactly TIMEOUT_CYCLES cycles, then fault follows in the next cycle.
- rst at any edge forces IDLE at that edge. A pending request is dropped with no wb_valid or fault, and mem_req is low in the following cycle.
- ex_valid while ex_ready=0 is ignored; upstream holds the op.

## Test plan
- LW at 0x8000_0010, mem_done one cycle after mem_req with mem_dout=0xDEADBEEF -> mem_addr 0x8000_0010, mem_we 0000, wb_valid two cycles after accept, wb_data 0xDEADBEEF, wb_rd=ex_rd.
- LB at 0x8000_0013 with word 0x80FF_0000 -> wb_data 0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LH at 0x8000_0002 -> 0xFFFF_80FF.
- SH at 0x8000_0006, wdata 0x1234_ABCD -> mem_we 1100, mem_din 0xABCD_ABCD, wb_valid with wb_rd=0, wb_data=0.
- SW at 0x0000_0100 -> fault cause 011, fault_addr 0x100, mem_req never asserted. LH at 0x8000_0001 -> cause 001. Load funct3 011 -> cause 100.
- LW with mem_done held low, TIMEOUT_CYCLES=4 -> mem_req high exactly 4 cycles, then fault cause 101, then ex_ready=1.
- rst asserted on the second REQ cycle of a load, then mem_done raised -> no wb_valid, mem_req low the next cycle, all outputs at reset values, ex_ready=1.
